// File: rtl/double_dabble_seq.sv
// -----------------------------------------------------------------------------
// double_dabble_seq
//   Sequential binary-to-BCD converter using the shift-and-add-3 (double
//   dabble) algorithm, one bit per clock. A conversion takes WIDTH iterations
//   after the accepted start edge; the result and overflow flag are registered
//   and held until the next conversion completes.
//
// Parameters
//   WIDTH    binary operand width (4..32)
//   DIGITS   number of BCD output digits (1..10)
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset (aborts any conversion)
//   start     in   conversion request, sampled in IDLE or DONE only
//   bin       in   unsigned operand, captured on the accepted start edge
//   busy      out  high while converting (state CONV)
//   done      out  one-cycle pulse in state DONE
//   bcd       out  result, digit i in bits [4i+3:4i], digit 0 = units
//   overflow  out  last result did not fit in DIGITS digits
//   blank     out  leading-zero mask (only when DD_BLANK_EN is defined)
//
// Configuration macro
//   DD_BLANK_EN  when defined, adds the blank output and its logic.
// -----------------------------------------------------------------------------
module double_dabble_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
`ifdef DD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      sr_q;       // binary shift register
  logic [4*DIGITS-1:0]   dig_q;      // working BCD digits
  logic                  acc_q;      // overflow accumulator
  logic [CNT_W-1:0]      cnt_q;      // iteration counter
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  ovf_q;

  logic                  accept;
  logic                  last_iter;
  logic [4*DIGITS-1:0]   dig_adj;
  logic [4*DIGITS-1:0]   dig_shift;
  logic                  carry_out;

  // Start is honoured only when no conversion is running.
  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_iter = (state_q == S_CONV) && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // One double-dabble iteration: add 3 to every digit >= 5 (no inter-digit
  // carry), then shift {digits, sr} left by one.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    dig_adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
    // The bit leaving the top digit is the value that no longer fits.
    carry_out = dig_adj[4*DIGITS-1];
    dig_shift = {dig_adj[4*DIGITS-2:0], sr_q[WIDTH-1]};
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CONV;
      S_CONV:  if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = start ? S_CONV : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded straight from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_CONV:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: working registers and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      dig_q <= '0;
      acc_q <= 1'b0;
      cnt_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        sr_q  <= bin;
        dig_q <= '0;
        acc_q <= 1'b0;
        cnt_q <= '0;
      end else if (state_q == S_CONV) begin
        sr_q  <= {sr_q[WIDTH-2:0], 1'b0};
        dig_q <= dig_shift;
        acc_q <= acc_q | carry_out;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // Result registers change only when a conversion completes.
      if (last_iter) begin
        bcd_q <= dig_shift;
        ovf_q <= acc_q | carry_out;
      end
    end
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;

`ifdef DD_BLANK_EN
  // ---------------------------------------------------------------------------
  // Leading-zero mask, registered alongside bcd. Digit 0 is never blanked so
  // a zero result still shows a single "0".
  // ---------------------------------------------------------------------------
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  logic [DIGITS-1:0] blank_q, blank_d;

  always_comb begin
    logic hz;
    hz      = 1'b1;
    blank_d = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hz         = hz && (dig_shift[4*i +: 4] == 4'd0);
      blank_d[i] = hz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= BLANK_RST;
    end else if (last_iter) begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_double_dabble_seq.sv
// -----------------------------------------------------------------------------
// tb_double_dabble_seq
//   Self-checking bench for double_dabble_seq. Three instances share one clock
//   and reset:
//     u_a  WIDTH=8,  DIGITS=3  main vectors, start-while-busy, reset abort
//     u_b  WIDTH=8,  DIGITS=2  overflow
//     u_c  WIDTH=16, DIGITS=5  full scale and back-to-back sweep 0..1000
//   Blank checks are compiled in when DD_BLANK_EN is defined.
// -----------------------------------------------------------------------------
module tb_double_dabble_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0]  bin_a = '0, bin_b = '0;
  logic [15:0] bin_c = '0;

  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic        busy_c, done_c, ovf_c;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [19:0] bcd_c;
`ifdef DD_BLANK_EN
  logic [2:0]  blank_a;
  logic [1:0]  blank_b;
  logic [4:0]  blank_c;
`endif

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  double_dabble_seq #(.WIDTH(8), .DIGITS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
`ifdef DD_BLANK_EN
    , .blank(blank_a)
`endif
  );

  double_dabble_seq #(.WIDTH(8), .DIGITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
`ifdef DD_BLANK_EN
    , .blank(blank_b)
`endif
  );

  double_dabble_seq #(.WIDTH(16), .DIGITS(5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c)
`ifdef DD_BLANK_EN
    , .blank(blank_c)
`endif
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [2:0]  blank;
  } vec_a_t;

  typedef struct {
    logic [7:0] bin;
    logic [7:0] bcd;
    logic       ovf;
  } vec_b_t;

  vec_a_t va[11];
  vec_b_t vb[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: digit i = (n / 10^i) % 10.
  function automatic logic [19:0] dec_bcd(input int n);
    logic [19:0] r;
    int m;
    m = n;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic drive(input int sel, input logic s, input logic [15:0] v);
    case (sel)
      0: begin start_a = s; bin_a = v[7:0]; end
      1: begin start_b = s; bin_b = v[7:0]; end
      default: begin start_c = s; bin_c = v; end
    endcase
  endtask

  function automatic logic sel_busy(input int sel);
    return (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  endfunction

  function automatic logic sel_done(input int sel);
    return (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
  endfunction

  // Pulse start for one edge, scramble bin after acceptance, then count edges
  // until done (inclusive of the start edge) and cycles spent busy.
  task automatic run(input int sel, input logic [15:0] v, output int lat, output int bc);
    drive(sel, 1'b1, v);
    lat = 0;
    bc  = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) drive(sel, 1'b0, ~v);
      if (sel_busy(sel)) bc++;
    end while (!sel_done(sel) && lat < 60);
  endtask

  initial begin
    int lat, bc, dn, cyc;

    va[0]  = '{8'd0,   12'h000, 3'b110};
    va[1]  = '{8'd7,   12'h007, 3'b110};
    va[2]  = '{8'd5,   12'h005, 3'b110};
    va[3]  = '{8'd9,   12'h009, 3'b110};
    va[4]  = '{8'd10,  12'h010, 3'b100};
    va[5]  = '{8'd50,  12'h050, 3'b100};
    va[6]  = '{8'd99,  12'h099, 3'b100};
    va[7]  = '{8'd100, 12'h100, 3'b000};
    va[8]  = '{8'd123, 12'h123, 3'b000};
    va[9]  = '{8'd200, 12'h200, 3'b000};
    va[10] = '{8'd255, 12'h255, 3'b000};

    vb[0] = '{8'd0,   8'h00, 1'b0};
    vb[1] = '{8'd99,  8'h99, 1'b0};
    vb[2] = '{8'd100, 8'h00, 1'b1};
    vb[3] = '{8'd255, 8'h55, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_bcd", bcd_a, 12'h000);
    check("rst_ovf", ovf_a, 1'b0);
`ifdef DD_BLANK_EN
    check("rst_blank_a", blank_a, 3'b110);
    check("rst_blank_b", blank_b, 2'b10);
`endif
    rst_n = 1'b1;

    // Main vectors (WIDTH=8, DIGITS=3); first start right after reset release
    for (int i = 0; i < 11; i++) begin
      run(0, {8'h00, va[i].bin}, lat, bc);
      check($sformatf("a_lat_%0d", va[i].bin), lat, 9);
      check($sformatf("a_busy_%0d", va[i].bin), bc, 8);
      check($sformatf("a_bcd_%0d", va[i].bin), bcd_a, va[i].bcd);
      check($sformatf("a_ovf_%0d", va[i].bin), ovf_a, 1'b0);
`ifdef DD_BLANK_EN
      check($sformatf("a_blank_%0d", va[i].bin), blank_a, va[i].blank);
`endif
      @(negedge clk);
      check($sformatf("a_done_pulse_%0d", va[i].bin), done_a, 1'b0);
    end

    // Overflow (DIGITS=2)
    for (int i = 0; i < 4; i++) begin
      run(1, {8'h00, vb[i].bin}, lat, bc);
      check($sformatf("b_lat_%0d", vb[i].bin), lat, 9);
      check($sformatf("b_bcd_%0d", vb[i].bin), bcd_b, vb[i].bcd);
      check($sformatf("b_ovf_%0d", vb[i].bin), ovf_b, vb[i].ovf);
    end

    // Start while busy: second request at cycle 3 is dropped
    bin_a = 8'd200; start_a = 1'b1;
    @(posedge clk); @(negedge clk);
    start_a = 1'b0; bin_a = 8'h5A;
    @(posedge clk); @(negedge clk);
    start_a = 1'b1; bin_a = 8'd17;
    @(posedge clk); @(negedge clk);
    start_a = 1'b0;
    check("hold_during_conv", bcd_a, 12'h255);
    check("busy_mid_conv", busy_a, 1'b1);
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_a) dn++;
    end
    check("busy_start_done_cnt", dn, 1);
    check("busy_start_bcd", bcd_a, 12'h200);
    run(0, 16'd17, lat, bc);
    check("after_busy_bcd", bcd_a, 12'h017);

    // Reset mid-conversion
    @(negedge clk);
    bin_a = 8'd123; start_a = 1'b1;
    @(posedge clk); @(negedge clk);
    start_a = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("pre_abort_busy", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy_a, 1'b0);
    check("abort_bcd", bcd_a, 12'h000);
    check("abort_done", done_a, 1'b0);
`ifdef DD_BLANK_EN
    check("abort_blank", blank_a, 3'b110);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_a) dn++;
    end
    check("abort_no_done", dn, 0);
    run(0, 16'd123, lat, bc);
    check("restart_lat", lat, 9);
    check("restart_bcd", bcd_a, 12'h123);

    // Width sweep: WIDTH=16, DIGITS=5 full scale
    run(2, 16'hFFFF, lat, bc);
    check("c_lat_65535", lat, 17);
    check("c_bcd_65535", bcd_c, 20'h65535);
    check("c_ovf_65535", ovf_c, 1'b0);

    // Back-to-back with start held high over 0..1000
    @(negedge clk);
    bin_c = 16'd0; start_c = 1'b1;
    @(posedge clk);
    #1 bin_c = 16'd1;
    for (int k = 0; k <= 1000; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done_c && cyc < 40);
      check($sformatf("b2b_period_%0d", k), cyc, 17);
      check($sformatf("b2b_bcd_%0d", k), bcd_c, dec_bcd(k));
      if (k == 1000) start_c = 1'b0;
      @(posedge clk);
      #1 bin_c = 16'(k + 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/double_dabble_seq.md
DOUBLE_DABBLE_SEQ -- requirements
Module: double_dabble_seq

Interface
REQ-001 Parameter WIDTH, default 8, binary input width, legal range 4..32.
REQ-002 Parameter DIGITS, default 3, number of BCD output digits, legal range 1..10.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  conversion request; sampled only in state IDLE or DONE.
REQ-006 bin  input  WIDTH  unsigned binary operand; captured on the accepted start edge.
REQ-007 busy  output  1  high while a conversion is in progress (state CONV).
REQ-008 done  output  1  single-cycle pulse; high only in state DONE.
REQ-009 bcd  output  4*DIGITS  result; digit i occupies bits [4i+3:4i], and digit 0 is the units digit.
REQ-010 overflow  output  1  high when the last result did not fit in DIGITS digits.
REQ-011 blank  output  DIGITS  leading-zero mask; present only with DD_BLANK_EN (see Configuration).

Function
REQ-012 The FSM SHALL have three states: IDLE, CONV and DONE. The transitions are:
- IDLE -> CONV on start.
- CONV -> DONE after exactly WIDTH iterations.
- DONE -> CONV on start.
- DONE -> IDLE otherwise.
REQ-013 Accepted start SHALL load the shift register from bin, clear the working BCD digits and the overflow accumulator, and clear the iteration counter.
REQ-014 Each CONV cycle SHALL perform one iteration:
- every working digit >= 5 gets +3 (4-bit, no carry between digits);
- then the concatenation {digits, shift register} is shifted left 1, with the binary MSB entering digit 0 bit 0.
REQ-015 A 1 shifted out of the top digit's bit 3 in any iteration SHALL set the overflow accumulator.
REQ-016 On the final iteration edge, bcd and overflow SHALL load the working result, and the state SHALL move to DONE.
- Latency: start edge to done-high equals WIDTH+1 cycles.
REQ-017 bcd and overflow SHALL hold their last result until the next conversion completes; they are not cleared by start.
REQ-018 start while in CONV SHALL be ignored; no queuing and no effect on the current conversion.
REQ-019 start held high continuously SHALL produce back-to-back conversions, with done pulsing once every WIDTH+1 cycles.
REQ-020 Change of bin after the accepted start edge SHALL NOT affect the result.
REQ-021 Outputs SHALL be registered; no combinational path from start or bin to any output.

Reset
REQ-022 rst_n low SHALL asynchronously force the following, including mid-conversion (which aborts with no done pulse):
- state IDLE and counter 0;
- busy=0, done=0, bcd=0, overflow=0;
- blank all-ones except bit 0.
REQ-023 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro DD_BLANK_EN controls the blank output.
- Defined: output blank[DIGITS-1:0] exists and updates together with bcd. blank[i]=1 when digit i and all higher digits are 0, for i>0; blank[0] is always 0.
- Undefined: the blank port and its logic are absent; all other behaviour is identical.

Verification (WIDTH=8, DIGITS=3 unless noted)
REQ-025 Full-scale value: bin=255, start pulse -> done after 9 cycles, bcd=12'h255, overflow=0, busy high for 8 cycles.
REQ-026 Zero and blanking (DD_BLANK_EN defined): bin=0 -> bcd=12'h000, blank=3'b110; then bin=7 -> bcd=12'h007, blank=3'b110.
REQ-027 Overflow (DIGITS=2): bin=99 -> bcd=8'h99, overflow=0; then bin=100 -> overflow=1.
REQ-028 Start while busy: bin=200, then start again at cycle 3 with bin=17 -> single done, bcd=12'h200; the next accepted start gives 12'h017.
REQ-029 Reset mid-conversion: assert rst_n low at cycle 4 of converting bin=123 -> immediate busy=0, bcd=0, no done; then restart with bin=123 -> bcd=12'h123.
REQ-030 Width sweep and back-to-back: WIDTH=16, DIGITS=5, bin=65535 -> bcd=20'h65535 after 17 cycles; start held high over values 0..1000 -> every result matches a decimal reference model.
